// File: rtl/alu_pkg.sv
// Shared FSM state encodings, operation codes and sizing helpers for the serial adder.
package alu_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  localparam logic OpAdd = 1'b0;
  localparam logic OpSub = 1'b1;

  // Counter must hold the value WIDTH itself, hence WIDTH+1.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used as the per-bit datapath of the serial adder.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/serial_add_unit.sv
// Bit-serial add/subtract unit: one result bit per clock, LSB first, through a single full adder.
module serial_add_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned      CntW     = cnt_width(WIDTH);
  localparam logic [CntW-1:0]  LastStep = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0]  CntOne   = CntW'(1);

  state_e             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  // Holds the WIDTH-1 low result bits; the MSB arrives straight from the adder on the last step.
  logic [WIDTH-2:0]   r_res;
  logic               r_carry;
  logic [CntW-1:0]    r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;

  logic               w_s;
  logic               w_c;
  logic [WIDTH-1:0]   w_res_full;

  full_adder u_full_adder (
    .i_a (r_a[0]),
    .i_b (r_b[0]),
    .i_c (r_carry),
    .o_s (w_s),
    .o_c (w_c)
  );

  assign w_res_full = {w_s, r_res};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_a     <= a;
            r_b     <= (op_sub == OpSub) ? ~b : b;
            r_carry <= (op_sub == OpAdd) ? cin : 1'b1;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= StShift;
          end
        end
        StShift: begin
          r_res   <= w_res_full[WIDTH-1:1];
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_c;
          r_cnt   <= r_cnt + CntOne;
          if (r_cnt == LastStep) begin
            // r_carry is the carry into the MSB at this step.
            r_sum   <= w_res_full;
            r_cout  <= w_c;
            r_ovf   <= r_carry ^ w_c;
            r_done  <= 1'b1;
            r_state <= StDone;
          end
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule
